// File: rtl/b02_line_sched.sv
// b02_line_sched
//
// Round-robin scheduler that time-shares one b02-class serial pattern
// recognizer among NCH serial line sources. Each granted slot has four
// phases:
//   FLUSH  - one cycle that restarts the recognizer
//   STREAM - FRAME_LEN cycles that stream the granted channel's bits
//   DRAIN  - one cycle so the detection for the last bit can come back
//   IDLE   - the scheduler returns here before the next slot
// Detections are credited to the granted channel as a one-cycle HIT pulse
// and a saturating per-channel counter.
//
// Ports:
//   clock     in   rising-edge clock
//   RESET_G   in   synchronous active-high reset
//   REQ       in   NCH request levels, sampled only in IDLE
//   LINEA_IN  in   NCH serial bits, one per channel
//   U_DET     in   registered detection output of the shared recognizer
//   LINEA     out  muxed serial bit to the recognizer (combinational)
//   REC_RST   out  one-cycle recognizer restart pulse (FLUSH)
//   GNT       out  one-hot grant, held for the whole slot
//   CUR_CH    out  granted channel index, held through IDLE
//   BUSY      out  high whenever the scheduler is not idle
//   HIT       out  one-cycle pulse on the channel credited with a detection
//   HIT_CNT   out  flattened saturating hit counters, CNT_W bits per channel

module b02_line_sched #(
    parameter int NCH       = 4,
    parameter int CW        = 2,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clock,
    input  logic                 RESET_G,
    input  logic [NCH-1:0]       REQ,
    input  logic [NCH-1:0]       LINEA_IN,
    input  logic                 U_DET,
    output logic                 LINEA,
    output logic                 REC_RST,
    output logic [NCH-1:0]       GNT,
    output logic [CW-1:0]        CUR_CH,
    output logic                 BUSY,
    output logic [NCH-1:0]       HIT,
    output logic [NCH*CNT_W-1:0] HIT_CNT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       bitCnt_q, bitCnt_d;
    logic [CW-1:0]    last_q, last_d;
    logic [CW-1:0]    curCh_q, curCh_d;
    logic [NCH-1:0]   gnt_q, gnt_d;
    logic             recRst_q, recRst_d;
    logic             busy_q, busy_d;
    logic [NCH-1:0]   hit_q, hit_d;
    logic [CNT_W-1:0] hitCnt_q [NCH];
    logic [CNT_W-1:0] hitCnt_d [NCH];

    logic [CW-1:0]    winner;
    logic             anyReq;
    logic             inWindow;

    // Round-robin pick: scan starting one past the last granted channel and
    // take the first requester found, so the last winner has lowest priority.
    always_comb begin
        int idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(last_q) + k) % NCH;
            if (!found && REQ[idx]) begin
                winner = CW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign anyReq = |REQ;

    // The attribution window is shifted one cycle behind the stream because
    // the recognizer's detection output is registered: a detection seen in
    // DRAIN still belongs to the bit streamed in the last STREAM cycle.
    assign inWindow = ((state_q == STREAM) && (bitCnt_q != 8'd0)) || (state_q == DRAIN);

    // State register: every registered signal, with synchronous reset taking
    // priority over any transition and clearing pending HIT pulses and counters.
    always_ff @(posedge clock) begin
        if (RESET_G) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            last_q   <= CW'(NCH - 1);
            curCh_q  <= '0;
            gnt_q    <= '0;
            recRst_q <= 1'b0;
            busy_q   <= 1'b0;
            hit_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                hitCnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            last_q   <= last_d;
            curCh_q  <= curCh_d;
            gnt_q    <= gnt_d;
            recRst_q <= recRst_d;
            busy_q   <= busy_d;
            hit_q    <= hit_d;
            for (int i = 0; i < NCH; i++) begin
                hitCnt_q[i] <= hitCnt_d[i];
            end
        end
    end

    // Next-state logic: a slot, once started, always runs to completion;
    // REQ only matters while idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (anyReq) state_d = FLUSH;
            FLUSH:   state_d = STREAM;
            STREAM:  if (bitCnt_q == 8'(FRAME_LEN - 1)) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, plus the
    // combinational serial mux. Grant and LAST are loaded when leaving IDLE
    // so they are visible during the FLUSH cycle itself.
    always_comb begin
        bitCnt_d = (state_q == STREAM) ? bitCnt_q + 8'd1 : 8'd0;
        last_d   = last_q;
        curCh_d  = curCh_q;
        gnt_d    = gnt_q;
        if (state_q == IDLE && anyReq) begin
            last_d  = winner;
            curCh_d = winner;
            gnt_d   = NCH'(1) << winner;
        end else if (state_d == IDLE) begin
            gnt_d = '0;
        end
        recRst_d = (state_d == FLUSH);
        busy_d   = (state_d != IDLE);

        hit_d = '0;
        for (int i = 0; i < NCH; i++) begin
            hitCnt_d[i] = hitCnt_q[i];
        end
        if (inWindow && U_DET) begin
            hit_d = NCH'(1) << curCh_q;
            if (hitCnt_q[curCh_q] != {CNT_W{1'b1}}) begin
                hitCnt_d[curCh_q] = hitCnt_q[curCh_q] + CNT_W'(1);
            end
        end

        LINEA = (state_q == STREAM) ? LINEA_IN[curCh_q] : 1'b0;
    end

    assign GNT     = gnt_q;
    assign CUR_CH  = curCh_q;
    assign REC_RST = recRst_q;
    assign BUSY    = busy_q;
    assign HIT     = hit_q;

    // Flatten the counter array onto the packed output bus.
    always_comb begin
        HIT_CNT = '0;
        for (int i = 0; i < NCH; i++) begin
            HIT_CNT[i*CNT_W +: CNT_W] = hitCnt_q[i];
        end
    end

endmodule

// File: tb/tb_b02_line_sched.sv
// tb_b02_line_sched
//
// Directed bench for b02_line_sched with NCH=4, FRAME_LEN=8 and CNT_W=2 so
// that counter saturation is reachable in a short run. Inputs are driven
// 1 time unit after each rising edge and outputs are checked there.

module tb_b02_line_sched;

    localparam int NCH       = 4;
    localparam int CW        = 2;
    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = 2;

    logic                 clock;
    logic                 RESET_G;
    logic [NCH-1:0]       REQ;
    logic [NCH-1:0]       LINEA_IN;
    logic                 U_DET;
    logic                 LINEA;
    logic                 REC_RST;
    logic [NCH-1:0]       GNT;
    logic [CW-1:0]        CUR_CH;
    logic                 BUSY;
    logic [NCH-1:0]       HIT;
    logic [NCH*CNT_W-1:0] HIT_CNT;

    int checkCount = 0;
    int passCount  = 0;

    b02_line_sched #(
        .NCH(NCH), .CW(CW), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .RESET_G(RESET_G), .REQ(REQ), .LINEA_IN(LINEA_IN),
        .U_DET(U_DET), .LINEA(LINEA), .REC_RST(REC_RST), .GNT(GNT),
        .CUR_CH(CUR_CH), .BUSY(BUSY), .HIT(HIT), .HIT_CNT(HIT_CNT)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    // Advance until the next FLUSH cycle, bounded; returns the cycles taken.
    task automatic waitFlush(output int cycles);
        cycles = 0;
        do begin
            applyStimulus();
            cycles++;
        end while (!REC_RST && cycles < 40);
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(HIT_CNT[ch*CNT_W +: CNT_W]);
    endfunction

    logic [7:0] pat;
    int n;

    initial begin
        RESET_G  = 1'b1;
        REQ      = 4'b1111;
        LINEA_IN = 4'b0000;
        U_DET    = 1'b0;
        pat      = 8'b1011_0010;

        // Reset held two cycles with every channel requesting.
        applyStimulus();
        applyStimulus();
        checkOutput("rst_gnt",    32'(GNT),     32'h0);
        checkOutput("rst_curch",  32'(CUR_CH),  32'h0);
        checkOutput("rst_recrst", 32'(REC_RST), 32'h0);
        checkOutput("rst_busy",   32'(BUSY),    32'h0);
        checkOutput("rst_hit",    32'(HIT),     32'h0);
        checkOutput("rst_hitcnt", 32'(HIT_CNT), 32'h0);
        checkOutput("rst_linea",  32'(LINEA),   32'h0);

        // First IDLE after release, then FLUSH for channel 0.
        RESET_G = 1'b0;
        checkOutput("idle_busy", 32'(BUSY), 32'h0);
        applyStimulus();
        checkOutput("first_gnt",    32'(GNT),     32'h1);
        checkOutput("first_recrst", 32'(REC_RST), 32'h1);
        checkOutput("first_busy",   32'(BUSY),    32'h1);

        // Round-robin rotation with FLUSH cycles 11 apart.
        for (int k = 1; k <= 4; k++) begin
            waitFlush(n);
            checkOutput($sformatf("rr_period_%0d", k), 32'(n), 32'd11);
            checkOutput($sformatf("rr_gnt_%0d", k), 32'(GNT), 32'(4'b0001 << (k % 4)));
            checkOutput($sformatf("rr_curch_%0d", k), 32'(CUR_CH), 32'(k % 4));
        end

        // Only channel 2 requests.
        REQ = 4'b0100;
        waitFlush(n);
        checkOutput("sparse_period", 32'(n), 32'd11);
        checkOutput("sparse_gnt", 32'(GNT), 32'h4);
        LINEA_IN = 4'b1111;
        #1;
        checkOutput("flush_linea", 32'(LINEA), 32'h0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            applyStimulus();
            LINEA_IN = {~pat[i], pat[i], ~pat[i], ~pat[i]};
            #1;
            checkOutput($sformatf("stream_linea_%0d", i), 32'(LINEA), 32'(pat[i]));
        end
        applyStimulus();
        LINEA_IN = 4'b1111;
        #1;
        checkOutput("drain_linea", 32'(LINEA), 32'h0);
        checkOutput("drain_gnt",   32'(GNT),   32'h4);
        applyStimulus();
        checkOutput("idle_linea", 32'(LINEA),  32'h0);
        checkOutput("idle_gnt",   32'(GNT),    32'h0);
        checkOutput("idle_curch", 32'(CUR_CH), 32'h2);
        checkOutput("idle_busy2", 32'(BUSY),   32'h0);
        applyStimulus();
        checkOutput("sparse_gnt2", 32'(GNT), 32'h4);
        LINEA_IN = 4'b0000;

        // Attribution on a channel 1 slot.
        REQ = 4'b0010;
        waitFlush(n);
        checkOutput("attr_period", 32'(n), 32'd11);
        checkOutput("attr_gnt", 32'(GNT), 32'h2);
        U_DET = 1'b1;
        applyStimulus();
        checkOutput("flush_det_hit", 32'(HIT), 32'h0);
        applyStimulus();
        U_DET = 1'b0;
        checkOutput("bit0_det_hit", 32'(HIT), 32'h0);
        applyStimulus();
        applyStimulus();
        U_DET = 1'b1;
        applyStimulus();
        U_DET = 1'b0;
        checkOutput("bit3_hit", 32'(HIT), 32'h2);
        checkOutput("bit3_cnt", cnt(1), 32'd1);
        applyStimulus();
        checkOutput("bit5_hit", 32'(HIT), 32'h0);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        U_DET = 1'b1;
        REQ   = 4'b1000;
        applyStimulus();
        U_DET = 1'b0;
        checkOutput("drain_hit",     32'(HIT), 32'h2);
        checkOutput("drain_hit_gnt", 32'(GNT), 32'h0);
        checkOutput("drain_cnt",     cnt(1),   32'd2);

        // Saturation on channel 3: detections at bits 1..4.
        applyStimulus();
        checkOutput("sat_gnt", 32'(GNT), 32'h8);
        applyStimulus();
        applyStimulus();
        U_DET = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("sat_hit_%0d", i), 32'(HIT), 32'h8);
            checkOutput($sformatf("sat_cnt_%0d", i), cnt(3), 32'(i > 3 ? 3 : i));
        end
        U_DET = 1'b0;
        REQ   = 4'b0010;
        applyStimulus();
        checkOutput("sat_hit_end", 32'(HIT), 32'h0);
        checkOutput("sat_cnt_end", cnt(3),   32'd3);
        checkOutput("sat_cnt1",    cnt(1),   32'd2);

        // Reset in the middle of a channel 1 slot.
        waitFlush(n);
        checkOutput("pre_rst_gnt", 32'(GNT), 32'h2);
        for (int i = 0; i < 6; i++) applyStimulus();
        U_DET   = 1'b1;
        RESET_G = 1'b1;
        REQ     = 4'b1111;
        applyStimulus();
        U_DET   = 1'b0;
        RESET_G = 1'b0;
        checkOutput("midrst_busy",   32'(BUSY),    32'h0);
        checkOutput("midrst_gnt",    32'(GNT),     32'h0);
        checkOutput("midrst_hit",    32'(HIT),     32'h0);
        checkOutput("midrst_hitcnt", 32'(HIT_CNT), 32'h0);
        checkOutput("midrst_curch",  32'(CUR_CH),  32'h0);
        applyStimulus();
        checkOutput("midrst_hit2",   32'(HIT),     32'h0);
        checkOutput("postrst_gnt",   32'(GNT),     32'h1);
        checkOutput("postrst_recrst", 32'(REC_RST), 32'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
